uart_frame_ctrl: RTL and testbench

UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

---
 rtl/uart_frame_ctrl_if.sv | 43 ++++
 rtl/uart_frame_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_ctrl_if.sv
// Bundles the UART receive/transmit handshakes and the pixel-memory write
// port of the frame controller. The slave side belongs to the controller;
// the master side belongs to whatever drives the UART and watches the writes.
interface uart_frame_ctrl_if #(
   parameter int ADDR_W = 16
);
   logic              i_Rx_DV;
   logic [7:0]        i_Rx_Byte;
   logic              o_Tx_DV;
   logic [7:0]        o_Tx_Byte;
   logic              i_Tx_Done;
   logic              o_Wr_En;
   logic [ADDR_W-1:0] o_Wr_Addr;
   logic [7:0]        o_Wr_Data;
   logic              o_Frame_Done;
   logic              o_Frame_Err;

   modport slave (
      input  i_Rx_DV,
      input  i_Rx_Byte,
      input  i_Tx_Done,
      output o_Tx_DV,
      output o_Tx_Byte,
      output o_Wr_En,
      output o_Wr_Addr,
      output o_Wr_Data,
      output o_Frame_Done,
      output o_Frame_Err
   );

   modport master (
      output i_Rx_DV,
      output i_Rx_Byte,
      output i_Tx_Done,
      input  o_Tx_DV,
      input  o_Tx_Byte,
      input  o_Wr_En,
      input  o_Wr_Addr,
      input  o_Wr_Data,
      input  o_Frame_Done,
      input  o_Frame_Err
   );
endinterface

// File: rtl/uart_frame_ctrl.sv
// UART frame controller: parses SYNC/LEN/ADDR/payload/CHK frames from a UART
// receiver, writes each payload byte into pixel memory at an auto-incrementing
// address, and answers every frame with an ACK or NAK byte. A frame that goes
// quiet for too long between bytes is answered with NAK. Payload writes are
// committed as they arrive, so a bad checksum only changes the response.
module uart_frame_ctrl #(
   parameter int         ADDR_W       = 16,
   parameter int         TIMEOUT_CLKS = 8700,
   parameter logic [7:0] ACK_BYTE     = 8'h06,
   parameter logic [7:0] NAK_BYTE     = 8'h15
) (
   input  logic               i_Clock,
   input  logic               i_Rst_n,
   uart_frame_ctrl_if.slave   bus
);

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         TO_W      = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_ADDR_HI,
      ST_ADDR_LO,
      ST_DATA,
      ST_CHK,
      ST_RESP,
      ST_WAIT_TX
   } state_e;

   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        addr_hi_q, addr_hi_d;
   logic [7:0]        chk_q, chk_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              tx_dv_q, tx_dv_d;
   logic [7:0]        tx_byte_q, tx_byte_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              frame_done_q, frame_done_d;
   logic              frame_err_q, frame_err_d;

   logic              in_frame;
   logic              timeout;
   logic              resp_go;
   logic              resp_ok;

   // Next-state, counters and registered-output values for the frame parser.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      addr_hi_d    = addr_hi_q;
      chk_d        = chk_q;
      to_cnt_d     = '0;
      tx_dv_d      = 1'b0;
      tx_byte_d    = tx_byte_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;
      resp_go      = 1'b0;
      resp_ok      = 1'b0;

      in_frame = (state_q == ST_LEN)     || (state_q == ST_ADDR_HI) ||
                 (state_q == ST_ADDR_LO) || (state_q == ST_DATA)    ||
                 (state_q == ST_CHK);

      // A byte arriving on the last allowed cycle still counts, so the
      // timeout only fires when no byte is present.
      timeout = in_frame && !bus.i_Rx_DV && (to_cnt_q == TO_LAST);

      if (in_frame && !bus.i_Rx_DV) begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.i_Rx_DV && (bus.i_Rx_Byte == SYNC_BYTE)) begin
               state_d = ST_LEN;
               cnt_d   = '0;
               chk_d   = '0;
            end
         end
         ST_LEN: begin
            if (bus.i_Rx_DV) begin
               if (bus.i_Rx_Byte == 8'h00) begin
                  resp_go = 1'b1;
               end else begin
                  cnt_d   = bus.i_Rx_Byte;
                  chk_d   = bus.i_Rx_Byte;
                  state_d = ST_ADDR_HI;
               end
            end
         end
         ST_ADDR_HI: begin
            if (bus.i_Rx_DV) begin
               addr_hi_d = bus.i_Rx_Byte;
               chk_d     = chk_q + bus.i_Rx_Byte;
               state_d   = ST_ADDR_LO;
            end
         end
         ST_ADDR_LO: begin
            if (bus.i_Rx_DV) begin
               addr_d  = ADDR_W'({addr_hi_q, bus.i_Rx_Byte});
               chk_d   = chk_q + bus.i_Rx_Byte;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bus.i_Rx_DV) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = bus.i_Rx_Byte;
               addr_d    = addr_q + ADDR_W'(1);
               chk_d     = chk_q + bus.i_Rx_Byte;
               cnt_d     = cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  state_d = ST_CHK;
               end
            end
         end
         ST_CHK: begin
            if (bus.i_Rx_DV) begin
               resp_go = 1'b1;
               resp_ok = (bus.i_Rx_Byte == chk_q);
            end
         end
         ST_RESP: begin
            state_d = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            if (bus.i_Tx_Done) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (timeout) begin
         resp_go = 1'b1;
         resp_ok = 1'b0;
      end

      // Entering RESP launches the response byte and the frame status pulse
      // together, so they line up on the same cycle.
      if (resp_go) begin
         state_d      = ST_RESP;
         tx_dv_d      = 1'b1;
         tx_byte_d    = resp_ok ? ACK_BYTE : NAK_BYTE;
         frame_done_d = resp_ok;
         frame_err_d  = !resp_ok;
      end
   end

   // State and output registers; reset abandons any frame in flight.
   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         addr_hi_q    <= '0;
         chk_q        <= '0;
         to_cnt_q     <= '0;
         tx_dv_q      <= 1'b0;
         tx_byte_q    <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         addr_hi_q    <= addr_hi_d;
         chk_q        <= chk_d;
         to_cnt_q     <= to_cnt_d;
         tx_dv_q      <= tx_dv_d;
         tx_byte_q    <= tx_byte_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign bus.o_Tx_DV      = tx_dv_q;
   assign bus.o_Tx_Byte    = tx_byte_q;
   assign bus.o_Wr_En      = wr_en_q;
   assign bus.o_Wr_Addr    = wr_addr_q;
   assign bus.o_Wr_Data    = wr_data_q;
   assign bus.o_Frame_Done = frame_done_q;
   assign bus.o_Frame_Err  = frame_err_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed testbench for uart_frame_ctrl: good/bad frames, address wrap,
// inter-byte timeout and its boundary, zero length, ignored bytes while a
// response is pending, reset mid-frame and back-to-back frames.
module tb_uart_frame_ctrl;

   localparam int         ADDR_W = 16;
   localparam int         TO     = 100;
   localparam logic [7:0] ACK    = 8'h06;
   localparam logic [7:0] NAK    = 8'h15;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic tx_done_r = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [15:0] wa_q[$];
   logic [7:0]  wd_q[$];
   int tx_cnt      = 0;
   int done_cnt    = 0;
   int err_cnt     = 0;
   int pulse_viol  = 0;
   int tx_unstable = 0;

   logic prev_wr   = 1'b0;
   logic prev_tx   = 1'b0;
   logic prev_done = 1'b0;
   logic prev_err  = 1'b0;

   logic       tx_busy = 1'b0;
   int         tx_wait = 0;
   logic [7:0] tx_hold = 8'h00;

   always #5 clk = ~clk;

   uart_frame_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   assign bus.i_Tx_Done = tx_done_r;

   uart_frame_ctrl #(
      .ADDR_W       (ADDR_W),
      .TIMEOUT_CLKS (TO),
      .ACK_BYTE     (ACK),
      .NAK_BYTE     (NAK)
   ) dut (
      .i_Clock (clk),
      .i_Rst_n (rst_n),
      .bus     (bus)
   );

   // Records writes and pulses, and flags any strobe held for two cycles.
   always @(negedge clk) begin
      if (bus.o_Wr_En === 1'b1) begin
         wa_q.push_back(bus.o_Wr_Addr);
         wd_q.push_back(bus.o_Wr_Data);
      end
      if (bus.o_Tx_DV === 1'b1) tx_cnt++;
      if (bus.o_Frame_Done === 1'b1) done_cnt++;
      if (bus.o_Frame_Err === 1'b1) err_cnt++;
      if ((prev_wr && bus.o_Wr_En) || (prev_tx && bus.o_Tx_DV) ||
          (prev_done && bus.o_Frame_Done) || (prev_err && bus.o_Frame_Err))
         pulse_viol++;
      prev_wr   = bus.o_Wr_En;
      prev_tx   = bus.o_Tx_DV;
      prev_done = bus.o_Frame_Done;
      prev_err  = bus.o_Frame_Err;
   end

   // Transmitter model: finishes a byte a few cycles after each request and
   // notes whether the byte stayed stable meanwhile.
   always @(negedge clk) begin
      if (tx_done_r) tx_done_r = 1'b0;
      if (!rst_n) begin
         tx_busy = 1'b0;
      end else if (tx_busy) begin
         if (bus.o_Tx_Byte !== tx_hold) tx_unstable++;
         if (tx_wait == 0) begin
            tx_done_r = 1'b1;
            tx_busy   = 1'b0;
         end else begin
            tx_wait--;
         end
      end
      if (rst_n && bus.o_Tx_DV === 1'b1) begin
         tx_busy = 1'b1;
         tx_wait = 4;
         tx_hold = bus.o_Tx_Byte;
      end
   end

   task automatic applyStimulus(input logic [7:0] b);
      @(negedge clk);
      bus.i_Rx_DV   = 1'b1;
      bus.i_Rx_Byte = b;
      @(negedge clk);
      bus.i_Rx_DV   = 1'b0;
   endtask

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
      tx_cnt   = 0;
      done_cnt = 0;
      err_cnt  = 0;
   endtask

   task automatic test_reset();
      logic [ADDR_W+19:0] snap;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      snap = {bus.o_Wr_En, bus.o_Tx_DV, bus.o_Frame_Done, bus.o_Frame_Err,
              bus.o_Tx_Byte, bus.o_Wr_Addr, bus.o_Wr_Data};
      checks++;
      if (snap !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h want 0", snap);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_good_frame();
      logic [15:0] ea [3];
      logic [7:0]  ed [3];
      ea = '{16'h0010, 16'h0011, 16'h0012};
      ed = '{8'h11, 8'h22, 8'h33};
      clear_log();
      applyStimulus(8'hA5); applyStimulus(8'h03);
      applyStimulus(8'h00); applyStimulus(8'h10);
      applyStimulus(8'h11);
      checks++;
      if ({bus.o_Wr_En, bus.o_Wr_Addr, bus.o_Wr_Data} !== {1'b1, 16'h0010, 8'h11}) begin
         errors++;
         $display("[TB] FAIL good_wr_latency: got en=%b %h@%h want en=1 11@0010",
                  bus.o_Wr_En, bus.o_Wr_Data, bus.o_Wr_Addr);
      end
      applyStimulus(8'h22); applyStimulus(8'h33);
      applyStimulus(8'h79);
      checks++;
      if ({bus.o_Tx_DV, bus.o_Frame_Done, bus.o_Frame_Err, bus.o_Tx_Byte} !== {3'b110, ACK}) begin
         errors++;
         $display("[TB] FAIL good_resp: got dv=%b done=%b err=%b byte=%h want 1 1 0 %h",
                  bus.o_Tx_DV, bus.o_Frame_Done, bus.o_Frame_Err, bus.o_Tx_Byte, ACK);
      end
      @(negedge clk);
      checks++;
      if (bus.o_Tx_DV !== 1'b0) begin
         errors++;
         $display("[TB] FAIL good_txdv_width: got %b want 0", bus.o_Tx_DV);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (wa_q.size() != 3) begin
         errors++;
         $display("[TB] FAIL good_wr_count: got %0d want 3", wa_q.size());
      end
      for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
         checks++;
         if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
            errors++;
            $display("[TB] FAIL good_wr%0d: got %h@%h want %h@%h", i, wd_q[i], wa_q[i], ed[i], ea[i]);
         end
      end
      checks++;
      if (done_cnt != 1 || err_cnt != 0 || tx_cnt != 1) begin
         errors++;
         $display("[TB] FAIL good_pulses: got done=%0d err=%0d tx=%0d want 1 0 1", done_cnt, err_cnt, tx_cnt);
      end
   endtask

   task automatic test_bad_chk();
      clear_log();
      applyStimulus(8'hA5); applyStimulus(8'h03);
      applyStimulus(8'h00); applyStimulus(8'h10);
      applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
      applyStimulus(8'h77);
      checks++;
      if ({bus.o_Tx_DV, bus.o_Frame_Done, bus.o_Frame_Err, bus.o_Tx_Byte} !== {3'b101, NAK}) begin
         errors++;
         $display("[TB] FAIL bad_resp: got dv=%b done=%b err=%b byte=%h want 1 0 1 %h",
                  bus.o_Tx_DV, bus.o_Frame_Done, bus.o_Frame_Err, bus.o_Tx_Byte, NAK);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (wa_q.size() != 3 || done_cnt != 0 || err_cnt != 1) begin
         errors++;
         $display("[TB] FAIL bad_summary: got writes=%0d done=%0d err=%0d want 3 0 1",
                  wa_q.size(), done_cnt, err_cnt);
      end
   endtask

   task automatic test_addr_wrap();
      clear_log();
      applyStimulus(8'hA5); applyStimulus(8'h02);
      applyStimulus(8'hFF); applyStimulus(8'hFF);
      applyStimulus(8'hAA); applyStimulus(8'hBB);
      applyStimulus(8'h65);
      repeat (10) @(negedge clk);
      checks++;
      if (wa_q.size() != 2) begin
         errors++;
         $display("[TB] FAIL wrap_wr_count: got %0d want 2", wa_q.size());
      end else begin
         checks++;
         if (wa_q[0] !== 16'hFFFF || wd_q[0] !== 8'hAA || wa_q[1] !== 16'h0000 || wd_q[1] !== 8'hBB) begin
            errors++;
            $display("[TB] FAIL wrap_writes: got %h@%h %h@%h want AA@FFFF BB@0000",
                     wd_q[0], wa_q[0], wd_q[1], wa_q[1]);
         end
      end
      checks++;
      if (done_cnt != 1 || tx_cnt != 1) begin
         errors++;
         $display("[TB] FAIL wrap_ack: got done=%0d tx=%0d want 1 1", done_cnt, tx_cnt);
      end
   endtask

   task automatic test_timeout();
      int   waited;
      logic seen;
      clear_log();
      applyStimulus(8'hA5); applyStimulus(8'h05);
      waited = 0;
      seen   = 1'b0;
      for (int i = 1; i <= TO + 10 && !seen; i++) begin
         @(negedge clk);
         if (bus.o_Tx_DV === 1'b1) begin
            seen   = 1'b1;
            waited = i;
            checks++;
            if (bus.o_Tx_Byte !== NAK || bus.o_Frame_Err !== 1'b1) begin
               errors++;
               $display("[TB] FAIL timeout_resp: got byte=%h err=%b want %h 1",
                        bus.o_Tx_Byte, bus.o_Frame_Err, NAK);
            end
         end
      end
      checks++;
      if (!seen || waited != TO) begin
         errors++;
         $display("[TB] FAIL timeout_latency: got seen=%b cycles=%0d want 1 %0d", seen, waited, TO);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (wa_q.size() != 0 || err_cnt != 1) begin
         errors++;
         $display("[TB] FAIL timeout_summary: got writes=%0d err=%0d want 0 1", wa_q.size(), err_cnt);
      end
      clear_log();
      applyStimulus(8'hA5); applyStimulus(8'h01);
      applyStimulus(8'h00); applyStimulus(8'h20);
      applyStimulus(8'h5C); applyStimulus(8'h7D);
      repeat (10) @(negedge clk);
      checks++;
      if (wa_q.size() != 1 || done_cnt != 1) begin
         errors++;
         $display("[TB] FAIL after_timeout_frame: got writes=%0d done=%0d want 1 1", wa_q.size(), done_cnt);
      end else begin
         checks++;
         if (wa_q[0] !== 16'h0020 || wd_q[0] !== 8'h5C) begin
            errors++;
            $display("[TB] FAIL after_timeout_write: got %h@%h want 5C@0020", wd_q[0], wa_q[0]);
         end
      end
   endtask

   task automatic test_timeout_race();
      clear_log();
      applyStimulus(8'hA5); applyStimulus(8'h01);
      repeat (TO - 2) @(negedge clk);
      applyStimulus(8'h12);
      applyStimulus(8'h34); applyStimulus(8'h5A);
      applyStimulus(8'hA1);
      repeat (10) @(negedge clk);
      checks++;
      if (err_cnt != 0 || done_cnt != 1 || tx_cnt != 1) begin
         errors++;
         $display("[TB] FAIL race_pulses: got err=%0d done=%0d tx=%0d want 0 1 1", err_cnt, done_cnt, tx_cnt);
      end
      checks++;
      if (wa_q.size() != 1) begin
         errors++;
         $display("[TB] FAIL race_wr_count: got %0d want 1", wa_q.size());
      end else begin
         checks++;
         if (wa_q[0] !== 16'h1234 || wd_q[0] !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL race_write: got %h@%h want 5A@1234", wd_q[0], wa_q[0]);
         end
      end
   endtask

   task automatic test_zero_len();
      clear_log();
      applyStimulus(8'h00); applyStimulus(8'hA5);
      applyStimulus(8'h00);
      checks++;
      if ({bus.o_Tx_DV, bus.o_Frame_Err, bus.o_Tx_Byte} !== {2'b11, NAK}) begin
         errors++;
         $display("[TB] FAIL zero_len_resp: got dv=%b err=%b byte=%h want 1 1 %h",
                  bus.o_Tx_DV, bus.o_Frame_Err, bus.o_Tx_Byte, NAK);
      end
      applyStimulus(8'hA5);
      repeat (8) @(negedge clk);
      applyStimulus(8'h01); applyStimulus(8'h00);
      applyStimulus(8'h00); applyStimulus(8'h55);
      applyStimulus(8'h56);
      repeat (10) @(negedge clk);
      checks++;
      if (wa_q.size() != 0 || tx_cnt != 1 || done_cnt != 0) begin
         errors++;
         $display("[TB] FAIL wait_tx_sync_ignored: got writes=%0d tx=%0d done=%0d want 0 1 0",
                  wa_q.size(), tx_cnt, done_cnt);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [ADDR_W+19:0] snap;
      clear_log();
      applyStimulus(8'hA5); applyStimulus(8'h03);
      applyStimulus(8'h00); applyStimulus(8'h10);
      applyStimulus(8'h11); applyStimulus(8'h22);
      rst_n = 1'b0;
      @(negedge clk);
      snap = {bus.o_Wr_En, bus.o_Tx_DV, bus.o_Frame_Done, bus.o_Frame_Err,
              bus.o_Tx_Byte, bus.o_Wr_Addr, bus.o_Wr_Data};
      checks++;
      if (snap !== '0) begin
         errors++;
         $display("[TB] FAIL midreset_outputs: got %h want 0", snap);
      end
      rst_n = 1'b1;
      applyStimulus(8'h33); applyStimulus(8'h79);
      repeat (10) @(negedge clk);
      checks++;
      if (wa_q.size() != 2 || tx_cnt != 0) begin
         errors++;
         $display("[TB] FAIL midreset_abandon: got writes=%0d tx=%0d want 2 0", wa_q.size(), tx_cnt);
      end
   endtask

   task automatic test_back_to_back();
      clear_log();
      applyStimulus(8'hA5); applyStimulus(8'h01);
      applyStimulus(8'h00); applyStimulus(8'h40);
      applyStimulus(8'h77); applyStimulus(8'hB8);
      repeat (7) @(negedge clk);
      applyStimulus(8'hA5); applyStimulus(8'h01);
      applyStimulus(8'h00); applyStimulus(8'h41);
      applyStimulus(8'h88); applyStimulus(8'hCA);
      repeat (10) @(negedge clk);
      checks++;
      if (wa_q.size() != 2 || done_cnt != 2 || tx_cnt != 2) begin
         errors++;
         $display("[TB] FAIL b2b_counts: got writes=%0d done=%0d tx=%0d want 2 2 2",
                  wa_q.size(), done_cnt, tx_cnt);
      end else begin
         checks++;
         if (wa_q[0] !== 16'h0040 || wd_q[0] !== 8'h77 || wa_q[1] !== 16'h0041 || wd_q[1] !== 8'h88) begin
            errors++;
            $display("[TB] FAIL b2b_writes: got %h@%h %h@%h want 77@0040 88@0041",
                     wd_q[0], wa_q[0], wd_q[1], wa_q[1]);
         end
      end
   endtask

   task automatic checkOutput();
      checks++;
      if (pulse_viol != 0) begin
         errors++;
         $display("[TB] FAIL pulse_width: got %0d stretched strobes want 0", pulse_viol);
      end
      checks++;
      if (tx_unstable != 0) begin
         errors++;
         $display("[TB] FAIL tx_byte_stable: got %0d changes want 0", tx_unstable);
      end
   endtask

   initial begin
      bus.i_Rx_DV   = 1'b0;
      bus.i_Rx_Byte = 8'h00;
      test_reset();
      test_good_frame();
      test_bad_chk();
      test_addr_wrap();
      test_timeout();
      test_timeout_race();
      test_zero_len();
      test_reset_mid_frame();
      test_back_to_back();
      checkOutput();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got no finish want finish before 1ms");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
